// File: rtl/conv_out_buffer_if.sv
// Stream and control bundle for conv_out_buffer.
// The slave modport is the buffer itself; master is the environment driving it.
interface conv_out_buffer_if #(
    parameter int unsigned CHANNEL_OUT_NUM = 8,
    parameter int unsigned PICTURE_NUM     = 1,
    parameter int unsigned WIDTH_DATA      = 8,
    parameter int unsigned DEPTH           = 64,
    parameter int unsigned WIDTH_BEAT_NUM  = 24
);
    localparam int unsigned W_BEAT = PICTURE_NUM * CHANNEL_OUT_NUM * WIDTH_DATA;
    localparam int unsigned W_FILL = $clog2(DEPTH) + 1;

    logic                      Start;
    logic [WIDTH_BEAT_NUM-1:0] Beat_Num_REG;
    logic [W_BEAT-1:0]         S_Data;
    logic                      S_Valid;
    logic                      Up_Ready;
    logic [W_BEAT-1:0]         M_Data;
    logic                      M_Valid;
    logic                      M_Ready;
    logic                      M_Last;
    logic                      Done;
    logic                      Overflow_Err;
    logic [W_FILL-1:0]         Fill_Count;

    modport slave (
        input  Start, Beat_Num_REG, S_Data, S_Valid, M_Ready,
        output Up_Ready, M_Data, M_Valid, M_Last, Done, Overflow_Err, Fill_Count
    );

    modport master (
        output Start, Beat_Num_REG, S_Data, S_Valid, M_Ready,
        input  Up_Ready, M_Data, M_Valid, M_Last, Done, Overflow_Err, Fill_Count
    );
endinterface

// File: rtl/conv_out_buffer.sv
// Output buffer after convolution quantisation: FWFT FIFO with early upstream ready,
// stream master toward the output DMA with per-layer last-beat and done generation.
module conv_out_buffer #(
    parameter int unsigned CHANNEL_OUT_NUM = 8,
    parameter int unsigned PICTURE_NUM     = 1,
    parameter int unsigned WIDTH_DATA      = 8,
    parameter int unsigned DEPTH           = 64,
    parameter int unsigned PIPE_LATENCY    = 16,
    parameter int unsigned WIDTH_BEAT_NUM  = 24
) (
    input  logic               clk,
    input  logic               rst,
    conv_out_buffer_if.slave   io_bus
);
    localparam int unsigned WD          = PICTURE_NUM * CHANNEL_OUT_NUM * WIDTH_DATA;
    localparam int unsigned AW          = $clog2(DEPTH);
    localparam int unsigned CW          = AW + 1;
    localparam int unsigned WB          = WIDTH_BEAT_NUM;
    // Largest occupancy that still leaves room for PIPE_LATENCY+1 beats in flight
    localparam int unsigned UP_MAX_FILL = DEPTH - PIPE_LATENCY - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [WD-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [WB-1:0]   r_wr_cnt;
    logic [WB-1:0]   r_rd_cnt;
    logic [WD-1:0]   r_m_data;
    logic            r_m_valid;
    logic            r_m_last;
    logic            r_done;
    logic            r_up_ready;
    logic            r_ovf;

    logic            w_start_go;
    logic            w_in_run;
    logic            w_full;
    logic            w_rd;
    logic            w_wr;
    logic            w_drop;
    logic            w_drop_full;
    logic            w_last_xfer;
    logic [AW-1:0]   w_wr_ptr_next;
    logic [AW-1:0]   w_rd_ptr_next;
    logic [CW-1:0]   w_count_next;
    logic [WB-1:0]   w_wr_cnt_next;
    logic [WB-1:0]   w_rd_cnt_next;
    logic [WD-1:0]   w_head_next;
    logic            w_ovf_next;
    logic            w_m_last_next;
    logic            w_up_ready_next;
    logic            w_done_next;

    // FIFO datapath, beat counters and error flag
    always_comb begin
        w_start_go    = (r_state == ST_IDLE) & io_bus.Start;
        w_in_run      = (r_state == ST_RUN);
        w_full        = (r_count == CW'(DEPTH));
        w_rd          = r_m_valid & io_bus.M_Ready;
        w_wr          = io_bus.S_Valid & w_in_run & (~w_full | w_rd);
        w_drop        = io_bus.S_Valid & ~w_wr;
        w_drop_full   = w_drop & w_in_run;
        w_last_xfer   = w_rd & r_m_last;

        w_wr_ptr_next = w_wr ? r_wr_ptr + AW'(1) : r_wr_ptr;
        w_rd_ptr_next = w_rd ? r_rd_ptr + AW'(1) : r_rd_ptr;
        w_count_next  = r_count + CW'(w_wr) - CW'(w_rd);

        w_wr_cnt_next = r_wr_cnt;
        if (w_start_go) begin
            w_wr_cnt_next = '0;
        end else if (io_bus.S_Valid & w_in_run & (r_wr_cnt < io_bus.Beat_Num_REG)) begin
            w_wr_cnt_next = r_wr_cnt + WB'(1);
        end

        // A dropped beat also advances the read position so the last surviving beat carries M_Last
        w_rd_cnt_next = r_rd_cnt;
        if (w_start_go) begin
            w_rd_cnt_next = '0;
        end else if ((w_rd | w_drop_full) & (r_rd_cnt < io_bus.Beat_Num_REG)) begin
            w_rd_cnt_next = r_rd_cnt + WB'(1);
        end

        // Bypass the incoming beat when it lands in the slot that becomes the head
        w_head_next   = (w_wr && (r_wr_ptr == w_rd_ptr_next)) ? io_bus.S_Data
                                                              : r_mem[w_rd_ptr_next];

        w_ovf_next    = w_start_go ? 1'b0 : (r_ovf | w_drop);
        w_m_last_next = (w_count_next != '0) &
                        (w_rd_cnt_next == io_bus.Beat_Num_REG - WB'(1));
    end

    // Layer FSM: next state and registered control outputs
    always_comb begin
        w_state_next    = r_state;
        w_done_next     = 1'b0;
        w_up_ready_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_go) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_wr_cnt_next == io_bus.Beat_Num_REG) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_last_xfer) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_up_ready_next = (w_state_next == ST_RUN) &
                          (w_count_next <= CW'(UP_MAX_FILL)) &
                          (w_wr_cnt_next < io_bus.Beat_Num_REG);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_m_data   <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_done     <= 1'b0;
            r_up_ready <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            r_wr_cnt   <= w_wr_cnt_next;
            r_rd_cnt   <= w_rd_cnt_next;
            r_m_data   <= w_head_next;
            r_m_valid  <= (w_count_next != '0);
            r_m_last   <= w_m_last_next;
            r_done     <= w_done_next;
            r_up_ready <= w_up_ready_next;
            r_ovf      <= w_ovf_next;
        end
    end

    // Storage carries no reset; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= io_bus.S_Data;
    end

    assign io_bus.M_Data       = r_m_data;
    assign io_bus.M_Valid      = r_m_valid;
    assign io_bus.M_Last       = r_m_last;
    assign io_bus.Done         = r_done;
    assign io_bus.Up_Ready     = r_up_ready;
    assign io_bus.Overflow_Err = r_ovf;
    assign io_bus.Fill_Count   = r_count;

endmodule

// File: tb/tb_conv_out_buffer.sv
// Randomised bench for conv_out_buffer, checked against a queue-based layer model.
module tb_conv_out_buffer;
    localparam int unsigned CH    = 8;
    localparam int unsigned PIC   = 1;
    localparam int unsigned WDAT  = 8;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned PIPE  = 16;
    localparam int unsigned WB    = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_out_buffer_if #(.CHANNEL_OUT_NUM(CH), .PICTURE_NUM(PIC), .WIDTH_DATA(WDAT),
                         .DEPTH(DEPTH), .WIDTH_BEAT_NUM(WB)) bus ();

    conv_out_buffer #(.CHANNEL_OUT_NUM(CH), .PICTURE_NUM(PIC), .WIDTH_DATA(WDAT),
                      .DEPTH(DEPTH), .PIPE_LATENCY(PIPE), .WIDTH_BEAT_NUM(WB))
        dut (.clk(clk), .rst(rst), .io_bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    // Layer model: phase 0 idle, 1 accepting beats, 2 draining
    logic [63:0] m_q[$];
    int          m_phase = 0;
    int          m_wcnt  = 0;
    int          m_beat  = 1;
    bit          m_ovf   = 1'b0;
    bit          m_done  = 1'b0;
    int          n_done  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        int sz;
        bit up_exp;
        sz     = m_q.size();
        up_exp = (m_phase == 1) && ((int'(DEPTH) - sz) > int'(PIPE) + 1) && (m_wcnt < m_beat);
        check("fill_count",   64'(bus.Fill_Count),   64'(sz));
        check("m_valid",      64'(bus.M_Valid),      64'(sz > 0));
        check("up_ready",     64'(bus.Up_Ready),     64'(up_exp));
        check("m_last",       64'(bus.M_Last),       64'((m_phase == 2) && (sz == 1)));
        check("done",         64'(bus.Done),         64'(m_done));
        check("overflow_err", 64'(bus.Overflow_Err), 64'(m_ovf));
        if (sz > 0) check("m_data", bus.M_Data, m_q[0]);
    endtask

    // Advance model by one clock using the inputs currently driven, then check the DUT
    task automatic cyc();
        bit rd, acc, lastx, run;
        int ph;
        ph    = m_phase;
        run   = (ph == 1);
        rd    = (m_q.size() > 0) && bus.M_Ready;
        lastx = rd && (ph == 2) && (m_q.size() == 1);
        acc   = bus.S_Valid && run && ((m_q.size() < int'(DEPTH)) || rd);
        if (rd)  void'(m_q.pop_front());
        if (acc) m_q.push_back(bus.S_Data);
        if (bus.Start && ph == 0) begin
            m_phase = 1;
            m_wcnt  = 0;
            m_ovf   = 1'b0;
        end else if (bus.S_Valid && !acc) begin
            m_ovf = 1'b1;
        end
        if (run && bus.S_Valid && m_wcnt < m_beat) begin
            m_wcnt++;
            if (m_wcnt == m_beat) m_phase = 2;
        end
        if (lastx) begin
            m_phase = 0;
            n_done++;
        end
        m_done = lastx;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic start_layer(input int beat);
        bus.Beat_Num_REG = WB'(beat);
        m_beat           = beat;
        bus.S_Valid      = 1'b0;
        bus.Start        = 1'b1;
        cyc();
        bus.Start        = 1'b0;
        n_done           = 0;
    endtask

    task automatic write_beats(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            bus.S_Valid = 1'b1;
            bus.S_Data  = (base < 0) ? {$urandom, $urandom} : 64'(base + i);
            cyc();
        end
        bus.S_Valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rnd);
        bit          seen;
        bit          stalled;
        logic [63:0] prev;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            bus.M_Ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            stalled     = bus.M_Valid && !bus.M_Ready;
            prev        = bus.M_Data;
            cyc();
            if (stalled) check({tag, "_hold"}, bus.M_Data, prev);
            if (m_done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'(1));
        bus.M_Ready = 1'b0;
        cyc();
        check({tag, "_done_once"}, 64'(n_done), 64'(1));
    endtask

    task automatic async_reset();
        #2;
        rst         = 1'b0;
        bus.S_Valid = 1'b0;
        bus.Start   = 1'b0;
        m_q.delete();
        m_phase = 0;
        m_wcnt  = 0;
        m_ovf   = 1'b0;
        m_done  = 1'b0;
        #1;
        check("rst_m_valid",  64'(bus.M_Valid),      64'(0));
        check("rst_up_ready", 64'(bus.Up_Ready),     64'(0));
        check("rst_fill",     64'(bus.Fill_Count),   64'(0));
        check("rst_ovf",      64'(bus.Overflow_Err), 64'(0));
        check("rst_done",     64'(bus.Done),         64'(0));
        check("rst_m_last",   64'(bus.M_Last),       64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        compare_all();
    endtask

    initial begin
        bit          pipe[$];
        bit          iss, sv, prev_up, fall_seen, done_seen;
        int          issued, seq, peak;

        bus.Start        = 1'b0;
        bus.Beat_Num_REG = WB'(1);
        bus.S_Data       = '0;
        bus.S_Valid      = 1'b0;
        bus.M_Ready      = 1'b0;

        // Power-on reset
        #12;
        check("por_m_valid",  64'(bus.M_Valid),      64'(0));
        check("por_up_ready", 64'(bus.Up_Ready),     64'(0));
        check("por_fill",     64'(bus.Fill_Count),   64'(0));
        check("por_ovf",      64'(bus.Overflow_Err), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        compare_all();

        // Basic stream of 1..10 with ready held high
        bus.M_Ready = 1'b1;
        start_layer(10);
        write_beats(10, 1);
        wait_done("basic", 50, 1'b0);
        check("basic_ovf", 64'(bus.Overflow_Err), 64'(0));

        // Backpressure: issue only on Up_Ready, deliver 16 cycles later
        bus.M_Ready = 1'b0;
        start_layer(100);
        for (int i = 0; i < int'(PIPE); i++) pipe.push_back(1'b0);
        issued = 0; seq = 0; peak = 0; fall_seen = 1'b0; done_seen = 1'b0;
        for (int c = 0; c < 3000 && !done_seen; c++) begin
            if (c == 300) bus.M_Ready = 1'b1;
            iss = bus.Up_Ready && (issued < 100);
            if (iss) issued++;
            sv = pipe.pop_front();
            pipe.push_back(iss);
            bus.S_Valid = sv;
            if (sv) begin
                seq++;
                bus.S_Data = 64'(seq);
            end
            prev_up = bus.Up_Ready;
            cyc();
            if (prev_up && !bus.Up_Ready && !fall_seen) begin
                fall_seen = 1'b1;
                check("bp_fall_fill", 64'(bus.Fill_Count), 64'(47));
            end
            if (int'(bus.Fill_Count) > peak) peak = int'(bus.Fill_Count);
            if (m_done) done_seen = 1'b1;
        end
        bus.S_Valid = 1'b0;
        check("bp_fell",      64'(fall_seen),        64'(1));
        check("bp_peak_ok",   64'(peak <= 64),       64'(1));
        check("bp_delivered", 64'(seq),              64'(100));
        check("bp_done",      64'(done_seen),        64'(1));
        check("bp_ovf",       64'(bus.Overflow_Err), 64'(0));
        cyc();

        // Forced overflow: 70 beats into a stalled FIFO
        bus.M_Ready = 1'b0;
        start_layer(70);
        write_beats(70, -1);
        check("ovf_fill", 64'(bus.Fill_Count),   64'(64));
        check("ovf_flag", 64'(bus.Overflow_Err), 64'(1));
        wait_done("ovf", 200, 1'b0);

        // Next Start clears the flag; single-beat layer under random ready
        start_layer(1);
        check("ovf_clear", 64'(bus.Overflow_Err), 64'(0));
        write_beats(1, -1);
        wait_done("single", 200, 1'b1);

        // Simultaneous read and write while full
        bus.M_Ready = 1'b0;
        start_layer(74);
        write_beats(64, 1000);
        check("full_fill", 64'(bus.Fill_Count), 64'(64));
        bus.M_Ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.S_Valid = 1'b1;
            bus.S_Data  = 64'(2000 + i);
            cyc();
            check("full_rw_fill", 64'(bus.Fill_Count), 64'(64));
        end
        bus.S_Valid = 1'b0;
        wait_done("full_rw", 200, 1'b0);
        check("full_rw_ovf", 64'(bus.Overflow_Err), 64'(0));

        // Reset mid-layer with 20 entries queued, then a clean 5-beat layer
        bus.M_Ready = 1'b0;
        start_layer(50);
        write_beats(20, -1);
        check("pre_rst_fill", 64'(bus.Fill_Count), 64'(20));
        async_reset();
        start_layer(5);
        write_beats(5, -1);
        wait_done("post_rst", 200, 1'b1);

        // Random layers with random valid and ready
        for (int l = 0; l < 4; l++) begin
            start_layer(int'($urandom_range(1, 120)));
            for (int g = 0; g < 2000 && m_phase == 1; g++) begin
                bus.S_Valid = ($urandom_range(0, 9) < 6);
                bus.S_Data  = {$urandom, $urandom};
                bus.M_Ready = ($urandom_range(0, 1) == 1);
                cyc();
            end
            bus.S_Valid = 1'b0;
            wait_done("rand", 1000, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
